// File: rtl/priority_enc_rr.sv
// priority_enc_rr: N-input registered priority/round-robin encoder with valid/ready output; PRIO_ONEHOT_EN adds a one-hot grant port
module priority_enc_rr #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [N-1:0]         D,
  input  logic                 ready,
  output logic [$clog2(N)-1:0] Y,
`ifdef PRIO_ONEHOT_EN
  output logic [N-1:0]         grant,
`endif
  output logic                 valid
);
  localparam int W = $clog2(N);
  logic [N-1:0] req;
  logic [W-1:0] ptr, ptr_next, start, win, c;
  logic [W:0]   s;
  logic         free;
  // channel c maps to D[N-1-c]; fixed mode is a search starting from channel 0
  always_comb begin
    req = {<<{D}};
    free = !valid || ready;
    ptr_next = (Y == W'(N-1)) ? '0 : Y + W'(1);
    start = !mode ? '0 : (valid && ready) ? ptr_next : ptr;
    s = '0;
    c = '0;
    win = '0;
    for (int k = N-1; k >= 0; k--) begin
      s = {1'b0, start} + (W+1)'(k);
      c = (s >= (W+1)'(N)) ? W'(s - (W+1)'(N)) : W'(s);
      if (req[c]) win = c;
    end
  end
  // output register loads when free; the rr pointer advances past the accepted channel
  always_ff @(posedge clk) begin
    if (rst) begin
      Y <= '0;
      valid <= 1'b0;
      ptr <= '0;
`ifdef PRIO_ONEHOT_EN
      grant <= '0;
`endif
    end else begin
      if (valid && ready) ptr <= ptr_next;
      if (free) begin
        valid <= |D;
        Y <= |D ? win : '0;
`ifdef PRIO_ONEHOT_EN
        grant <= |D ? {1'b1, {(N-1){1'b0}}} >> win : '0;
`endif
      end
    end
  end
endmodule
